// File: rtl/ap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ap_ctrl_pkg
//  Brief    : Shared op encodings, FSM states and defaults for the AP host sequencer.
//  Revision : 1.0
// ============================================================================
package ap_ctrl_pkg;

    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RUN_CYCLES = 17;

    localparam logic [2:0] c_op_load_a = 3'd0;
    localparam logic [2:0] c_op_load_b = 3'd1;
    localparam logic [2:0] c_op_read_a = 3'd2;
    localparam logic [2:0] c_op_read_b = 3'd3;
    localparam logic [2:0] c_op_run    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RUN      = 3'd4,
        ST_RUN_EXIT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ap_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ap_ctrl_addr_gen
//  Brief    : Block row walker: latched base/len, index counter, wrapping row address.
//  Revision : 1.0
// ============================================================================
module ap_ctrl_addr_gen #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              last
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W:0]   w_sum_next;

    // base + idx never exceeds 2*DEPTH-1, so one conditional subtract is a full mod
    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W:0] sum);
        logic [ADDR_W:0] w;
        w = (sum >= c_depth) ? (sum - c_depth) : sum;
        return w[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_idx  <= '0;
        end else if (start) begin
            r_base <= base;
            r_len  <= len;
            r_idx  <= '0;
        end else if (step) begin
            r_idx  <= r_idx + ADDR_W'(1);
        end
    end

    assign w_sum      = {1'b0, r_base} + {1'b0, r_idx};
    assign w_sum_next = w_sum + c_one;
    assign addr       = wrap(w_sum);
    assign addr_next  = wrap(w_sum_next);
    assign last       = ({1'b0, r_idx} == (r_len - c_one));

endmodule
`default_nettype wire

// File: rtl/ap_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ap_host_sequencer
//  Brief    : Command FSM that masters the associative processor: block load/read and RUN.
//  Revision : 1.0
// ============================================================================
module ap_host_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [2:0]        cmd_arg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ap_mode,
    output logic [2:0]        ap_cmd,
    output logic              ap_write_en,
    output logic              ap_sel_col,
    output logic [ADDR_W-1:0] ap_addr,
    output logic [DATA_W-1:0] ap_data,
    input  logic [DATA_W-1:0] ap_data_out,
    input  logic              ap_irq
);

    localparam int              TW         = $clog2(RUN_CYCLES + 1);
    localparam logic [ADDR_W:0] c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [TW-1:0]   c_run_last = TW'(RUN_CYCLES - 1);

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic              r_addr_ok;
    logic              r_irq_d;

    logic              w_accept;
    logic              w_illegal;
    logic              w_irq_edge;
    logic              w_gen_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid && cmd_ready;
    assign w_illegal  = (cmd_op > c_op_run) || (cmd_len == '0) || (cmd_len > c_depth);
    assign w_irq_edge = ap_irq && !r_irq_d;
    assign w_gen_step = ((r_state == ST_LOAD) && in_valid) ||
                        ((r_state == ST_RD_WAIT) && out_ready && !w_last);

    ap_ctrl_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept),
        .step      (w_gen_step),
        .base      (cmd_base),
        .len       (cmd_len),
        .addr      (w_addr),
        .addr_next (w_addr_next),
        .last      (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_addr_ok   <= 1'b0;
            r_irq_d     <= 1'b0;
            cmd_ready   <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ap_mode     <= 1'b0;
            ap_cmd      <= '0;
            ap_write_en <= 1'b0;
            ap_sel_col  <= 1'b0;
            ap_addr     <= '0;
            ap_data     <= '0;
        end else begin
            r_irq_d <= ap_irq;
            done    <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (w_accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (w_illegal) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (cmd_op == c_op_run) begin
                            ap_mode <= 1'b1;
                            ap_cmd  <= cmd_arg;
                            r_timer <= '0;
                            r_state <= ST_RUN;
                        end else if (cmd_op == c_op_load_a || cmd_op == c_op_load_b) begin
                            ap_sel_col <= cmd_op[0];
                            in_ready   <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            ap_sel_col <= cmd_op[0];
                            r_addr_ok  <= 1'b0;
                            r_state    <= ST_RD_FETCH;
                        end
                    end
                end
                ST_LOAD: begin
                    ap_write_en <= in_valid;
                    if (in_valid) begin
                        ap_addr <= w_addr;
                        ap_data <= in_data;
                        if (w_last) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                // First visit only sets the row; later visits find it prefetched at the handshake
                ST_RD_FETCH: begin
                    if (!r_addr_ok) begin
                        ap_addr   <= w_addr;
                        r_addr_ok <= 1'b1;
                    end else begin
                        out_data  <= ap_data_out;
                        out_valid <= 1'b1;
                        r_state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            ap_addr <= w_addr_next;
                            r_state <= ST_RD_FETCH;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_irq_edge || (r_timer == c_run_last)) begin
                        ap_mode <= 1'b0;
                        r_state <= ST_RUN_EXIT;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_RUN_EXIT: begin
                    ap_cmd  <= '0;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    ap_write_en <= 1'b0;
                    busy        <= 1'b0;
                    cmd_ready   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
